// File: rtl/cascade_slave_responder.sv
// ============================================================================
// cascade_slave_responder : 8259A slave-side cascade responder. It tracks the
// INTA pulses, matches CAS against the ICW3 ID and drives the vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cascade_slave_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp,
  input  logic [2:0] icw3_id,
  input  logic [2:0] cas,
  input  logic       inta_n,
  input  logic       int_pending,
  input  logic [7:0] vector,
  input  logic       eoi,
  output logic       selected,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ack_done,
  output logic       timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACK1  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_SKIP  = 3'd3;
  localparam logic [2:0] S_ACK2  = 3'd4;
  localparam logic [2:0] S_SKIP2 = 3'd5;

  // The counter clears on GAP/SKIP entry, so TIMEOUT-1 is its last in-range value.
  localparam logic [7:0] C_GAP_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_inta_q;
  logic [7:0] r_gap_cnt;

  logic w_fall;
  logic w_rise;
  logic w_match;
  logic w_gap_expired;

  logic w_set_sel;
  logic w_clr_sel;
  logic w_load_vec;
  logic w_oe_off;
  logic w_ack_pulse;
  logic w_to_pulse;
  logic w_cnt_clr;
  logic w_cnt_inc;

  assign w_fall        = r_inta_q & ~inta_n;
  assign w_rise        = ~r_inta_q & inta_n;
  assign w_match       = (cas == icw3_id) && int_pending;
  assign w_gap_expired = (r_gap_cnt == C_GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inta_q <= 1'b1;
    end else begin
      r_inta_q <= inta_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (sp) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) w_next_state = S_ACK1;
        end
        S_ACK1: begin
          if (w_rise) w_next_state = w_match ? S_GAP : S_SKIP;
        end
        S_GAP: begin
          if (w_fall)             w_next_state = S_ACK2;
          else if (w_gap_expired) w_next_state = S_IDLE;
        end
        S_SKIP: begin
          if (w_fall)             w_next_state = S_SKIP2;
          else if (w_gap_expired) w_next_state = S_IDLE;
        end
        S_ACK2: begin
          if (w_rise) w_next_state = S_IDLE;
        end
        S_SKIP2: begin
          if (w_rise) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // A fall in GAP/SKIP wins over an expiring counter on the same cycle.
  always_comb begin
    w_set_sel   = 1'b0;
    w_clr_sel   = 1'b0;
    w_load_vec  = 1'b0;
    w_oe_off    = 1'b0;
    w_ack_pulse = 1'b0;
    w_to_pulse  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (!sp) begin
      case (r_state)
        S_IDLE: begin
          w_clr_sel = eoi;
        end
        S_ACK1: begin
          if (w_rise) begin
            w_cnt_clr = 1'b1;
            w_set_sel = w_match;
          end
        end
        S_GAP, S_SKIP: begin
          if (w_fall) begin
            w_load_vec = (r_state == S_GAP);
          end else if (w_gap_expired) begin
            w_to_pulse = 1'b1;
            w_clr_sel  = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        S_ACK2: begin
          if (w_rise) begin
            w_oe_off    = 1'b1;
            w_ack_pulse = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selected    <= 1'b0;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
      ack_done    <= 1'b0;
      timeout_err <= 1'b0;
      r_gap_cnt   <= 8'h00;
    end else if (sp) begin
      selected    <= 1'b0;
      data_oe     <= 1'b0;
      ack_done    <= 1'b0;
      timeout_err <= 1'b0;
      r_gap_cnt   <= 8'h00;
    end else begin
      ack_done    <= w_ack_pulse;
      timeout_err <= w_to_pulse;
      if (w_set_sel) begin
        selected <= 1'b1;
      end else if (w_clr_sel) begin
        selected <= 1'b0;
      end
      if (w_load_vec) begin
        data_out <= vector;
        data_oe  <= 1'b1;
      end else if (w_oe_off) begin
        data_oe <= 1'b0;
      end
      if (w_cnt_clr) begin
        r_gap_cnt <= 8'h00;
      end else if (w_cnt_inc) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cascade_slave_responder.sv
// ============================================================================
// tb_cascade_slave_responder : per-cycle vector table plus hand-written
// async-reset sequence for cascade_slave_responder (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cascade_slave_responder;

  logic       clk;
  logic       reset;
  logic       sp;
  logic [2:0] icw3_id;
  logic [2:0] cas;
  logic       inta_n;
  logic       int_pending;
  logic [7:0] vector;
  logic       eoi;
  logic       selected;
  logic [7:0] data_out;
  logic       data_oe;
  logic       ack_done;
  logic       timeout_err;

  int checks;
  int errors;

  typedef struct {
    logic       sp;
    logic [2:0] cas;
    logic       pend;
    logic [7:0] vec;
    logic       eoi;
    logic       inta;
    logic       e_sel;
    logic       e_oe;
    logic [7:0] e_dout;
    logic       e_ack;
    logic       e_to;
    logic       chk_dout;
  } vec_t;

  vec_t tbl[$];

  cascade_slave_responder #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sp          (sp),
    .icw3_id     (icw3_id),
    .cas         (cas),
    .inta_n      (inta_n),
    .int_pending (int_pending),
    .vector      (vector),
    .eoi         (eoi),
    .selected    (selected),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .ack_done    (ack_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, input logic [2:0] c, input logic p, input logic [7:0] v,
                     input logic e, input logic ia, input logic xs, input logic xo,
                     input logic [7:0] xd, input logic xa, input logic xt, input logic cd);
    vec_t r;
    r.sp = s; r.cas = c; r.pend = p; r.vec = v; r.eoi = e; r.inta = ia;
    r.e_sel = xs; r.e_oe = xo; r.e_dout = xd; r.e_ack = xa; r.e_to = xt; r.chk_dout = cd;
    tbl.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Addressed slave: 3-cycle pulses, 4-cycle gap, vector 4A
    add(0,6,1,8'h4A,0,1, 0,0,8'h00,0,0,1);
    repeat (3) add(0,6,1,8'h4A,0,0, 0,0,8'h00,0,0,1);
    repeat (4) add(0,6,1,8'h4A,0,1, 1,0,8'h00,0,0,1);
    repeat (3) add(0,6,1,8'h4A,0,0, 1,1,8'h4A,0,0,1);
    add(0,6,1,8'h4A,0,1, 1,0,8'h4A,1,0,1);
    add(0,6,1,8'h4A,0,1, 1,0,8'h4A,0,0,1);
    add(0,6,1,8'h4A,1,1, 0,0,8'h4A,0,0,1);
    add(0,6,1,8'h4A,0,1, 0,0,8'h4A,0,0,1);
    // Not addressed (cas 101)
    repeat (3) add(0,5,1,8'h4A,0,0, 0,0,8'h4A,0,0,1);
    repeat (4) add(0,5,1,8'h4A,0,1, 0,0,8'h4A,0,0,1);
    repeat (3) add(0,5,1,8'h4A,0,0, 0,0,8'h4A,0,0,1);
    repeat (2) add(0,5,1,8'h4A,0,1, 0,0,8'h4A,0,0,1);
    // Matching cas but no pending request
    repeat (3) add(0,6,0,8'h33,0,0, 0,0,8'h4A,0,0,1);
    repeat (4) add(0,6,0,8'h33,0,1, 0,0,8'h4A,0,0,1);
    repeat (3) add(0,6,0,8'h33,0,0, 0,0,8'h4A,0,0,1);
    repeat (2) add(0,6,0,8'h33,0,1, 0,0,8'h4A,0,0,1);
    // 1-cycle pulses, eoi during GAP and ACK2 is ignored
    add(0,6,1,8'h5C,0,0, 0,0,8'h4A,0,0,1);
    add(0,6,1,8'h5C,0,1, 1,0,8'h4A,0,0,1);
    add(0,6,1,8'h5C,1,1, 1,0,8'h4A,0,0,1);
    add(0,6,1,8'h5C,1,1, 1,0,8'h4A,0,0,1);
    add(0,6,1,8'h5C,1,0, 1,1,8'h5C,0,0,1);
    add(0,6,1,8'h5C,0,1, 1,0,8'h5C,1,0,1);
    add(0,6,1,8'h5C,0,1, 1,0,8'h5C,0,0,1);
    add(0,6,1,8'h5C,1,1, 0,0,8'h5C,0,0,1);
    // Second sequence to the same ID
    add(0,6,1,8'hA7,0,0, 0,0,8'h5C,0,0,1);
    add(0,6,1,8'hA7,0,1, 1,0,8'h5C,0,0,1);
    add(0,6,1,8'hA7,0,0, 1,1,8'hA7,0,0,1);
    add(0,6,1,8'hA7,0,1, 1,0,8'hA7,1,0,1);
    add(0,6,1,8'hA7,1,1, 0,0,8'hA7,0,0,1);
    // Gap timeout: error pulse 8 cycles after the rise
    add(0,6,1,8'h77,0,0, 0,0,8'hA7,0,0,1);
    add(0,6,1,8'h77,0,1, 1,0,8'hA7,0,0,1);
    repeat (7) add(0,6,1,8'h77,0,1, 1,0,8'hA7,0,0,1);
    add(0,6,1,8'h77,0,1, 0,0,8'hA7,0,1,1);
    add(0,6,1,8'h77,0,1, 0,0,8'hA7,0,0,1);
    // Block must be back in IDLE: next fall is a first pulse again
    add(0,6,1,8'h11,0,0, 0,0,8'hA7,0,0,1);
    add(0,6,1,8'h11,0,1, 1,0,8'hA7,0,0,1);
    add(0,6,1,8'h11,0,0, 1,1,8'h11,0,0,1);
    add(0,6,1,8'h11,0,1, 1,0,8'h11,1,0,1);
    add(0,6,1,8'h11,0,1, 1,0,8'h11,0,0,1);
    // Master mode clears selected and ignores all activity
    add(1,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,0, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,1,0, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,0, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,0, 0,0,8'h00,0,0,0);
    add(1,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);
    add(0,6,1,8'h22,0,1, 0,0,8'h00,0,0,0);

    reset = 1'b1; sp = 1'b0; icw3_id = 3'b110; cas = 3'b000; inta_n = 1'b1;
    int_pending = 1'b0; vector = 8'h00; eoi = 1'b0;
    cyc();
    cyc();
    chk("rst selected",    {7'd0, selected},    8'h00);
    chk("rst data_out",    data_out,            8'h00);
    chk("rst data_oe",     {7'd0, data_oe},     8'h00);
    chk("rst ack_done",    {7'd0, ack_done},    8'h00);
    chk("rst timeout_err", {7'd0, timeout_err}, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t r;
      r = tbl[i];
      sp = r.sp; cas = r.cas; int_pending = r.pend; vector = r.vec; eoi = r.eoi; inta_n = r.inta;
      cyc();
      checks++;
      if (selected !== r.e_sel || data_oe !== r.e_oe || ack_done !== r.e_ack ||
          timeout_err !== r.e_to || (r.chk_dout && data_out !== r.e_dout)) begin
        errors++;
        $display("FAIL vec[%0d]: got sel=%b oe=%b dout=%h ack=%b to=%b expected sel=%b oe=%b dout=%h ack=%b to=%b",
                 i, selected, data_oe, data_out, ack_done, timeout_err,
                 r.e_sel, r.e_oe, r.e_dout, r.e_ack, r.e_to);
      end
    end

    // Asynchronous reset while driving the vector in ACK2
    sp = 1'b0; cas = 3'b110; int_pending = 1'b1; vector = 8'h9E; eoi = 1'b0;
    inta_n = 1'b0; cyc();
    inta_n = 1'b1; cyc();
    inta_n = 1'b0; cyc();
    chk("ack2 data_oe",   {7'd0, data_oe},  8'h01);
    chk("ack2 data_out",  data_out,         8'h9E);
    chk("ack2 selected",  {7'd0, selected}, 8'h01);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async data_oe",  {7'd0, data_oe},  8'h00);
    chk("async selected", {7'd0, selected}, 8'h00);
    chk("async data_out", data_out,         8'h00);
    inta_n = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("post selected",  {7'd0, selected},    8'h00);
    chk("post data_oe",   {7'd0, data_oe},     8'h00);
    chk("post ack_done",  {7'd0, ack_done},    8'h00);
    chk("post timeout",   {7'd0, timeout_err}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cascade_slave_responder.md
# cascade_slave_responder

Slave-side end of the 8259A cascade protocol. It tracks the CPU INTA pulse sequence, compares the CAS lines driven by the master against this device's ICW3 slave ID, and, when addressed, drives the interrupt vector onto the data bus during the second INTA pulse. It sits between the cascade bus and the slave's control logic/data-bus buffer, and is inert when the device is programmed as master (SP=1).

## Interface

Parameters:
- TIMEOUT, 255: maximum clk cycles allowed between the end of the first INTA pulse and the start of the second. Range 1–255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sp  in  1  1 = master (block idle), 0 = slave (block active)
- icw3_id  in  3  own slave ID, ICW3[2:0]
- cas  in  3  cascade lines as driven by the master
- inta_n  in  1  CPU interrupt acknowledge, active low, already synchronous to clk
- int_pending  in  1  this slave currently has an unacknowledged request (its INT is high)
- vector  in  8  vector byte from the control logic
- eoi  in  1  end-of-interrupt pulse from the control logic
- selected  out  1  this slave was addressed in the current or last INTA cycle; held until EOI
- data_out  out  8  vector driven to the data-bus buffer
- data_oe  out  1  data-bus output enable
- ack_done  out  1  one-cycle pulse when a full two-pulse sequence completes
- timeout_err  out  1  one-cycle pulse on an INTA-gap timeout

## Operation

- inta_q is a register holding the previous inta_n, reset to 1. fall = inta_q & ~inta_n. rise = ~inta_q & inta_n.
- States:
  - IDLE: waiting for the first pulse.
  - ACK1: first pulse in progress.
  - GAP: addressed; waiting for the second pulse.
  - SKIP: not addressed; waiting for the second pulse.
  - ACK2: driving the vector.
  - SKIP2: second pulse in progress, not driving.
- IDLE -> ACK1 on fall.
- ACK1 on rise:
  - If cas == icw3_id and int_pending: set selected = 1 and go to GAP.
  - Otherwise go to SKIP.
- GAP -> ACK2 on fall. On the same edge:
  - latch vector into data_out
  - set data_oe = 1
- SKIP -> SKIP2 on fall.
- ACK2 -> IDLE on rise. On that edge: data_oe = 0 and ack_done = 1 for one cycle. data_out holds its value.
- SKIP2 -> IDLE on rise. No ack_done.
- Gap counter (8 bits):
  - Cleared on entry to GAP or SKIP.
  - Increments each cycle spent in GAP or SKIP.
  - When it reaches TIMEOUT with no fall: go to IDLE, clear selected, pulse timeout_err.
- selected:
  - Cleared by eoi only while in IDLE.
  - An eoi arriving in any other state is ignored; it is not queued.
- sp = 1 synchronously forces IDLE, selected = 0, data_oe = 0. All inputs are ignored while sp = 1.
- cas is sampled only on the ACK1 rise edge. Changes at any other time have no effect.
- vector is sampled only on the GAP -> ACK2 edge.

## Timing

- Reset values:
  - state = IDLE
  - selected = 0
  - data_out = 8'h00
  - data_oe = 0
  - ack_done = 0
  - timeout_err = 0
  - gap counter = 0
  - inta_q = 1
- Reset asserted mid-sequence returns the block to IDLE immediately. data_oe drops without waiting for clk.
- Latency:
  - data_oe rises at the first clk edge that samples inta_n = 0 in GAP.
  - data_oe falls at the first clk edge that samples inta_n = 1 in ACK2.
- selected rises at the clk edge that samples the end of the first pulse.
- ack_done and timeout_err are registered and last exactly one cycle.
- Minimum supported pulse width: 1 cycle low and 1 cycle high.
- A new fall in ACK1 or ACK2 cannot occur (inta_n is already low), so no extra handling is needed.
- A third pulse after returning to IDLE starts a new sequence.

## Test plan

- Addressed slave:
  - Stimulus: sp=0, icw3_id=3'b110, int_pending=1, cas=3'b110, vector=8'h4A; two INTA pulses of 3 cycles each with a 4-cycle gap.
  - Response: selected=1 after pulse 1; data_oe=1 with data_out=8'h4A during pulse 2 only; one ack_done pulse; selected stays 1 until eoi in IDLE.
- Not addressed:
  - Stimulus: as above but cas=3'b101.
  - Response: selected=0, data_oe never 1, no ack_done; state returns to IDLE after pulse 2.
- Addressed but no request:
  - Stimulus: cas matches, int_pending=0.
  - Response: SKIP path taken; data_oe stays 0.
- Gap timeout:
  - Stimulus: TIMEOUT=8; addressed first pulse, no second pulse.
  - Response: timeout_err pulses 8 cycles after the rise; selected=0; state IDLE.
- EOI and back-to-back sequences:
  - Stimulus: eoi asserted during GAP.
  - Response: ignored, selected stays 1.
  - Stimulus: eoi asserted in IDLE.
  - Response: selected clears next cycle.
  - Stimulus: second full sequence to the same ID.
  - Response: selected set again and the vector driven again.
- Reset and master mode:
  - Stimulus: reset asserted while in ACK2.
  - Response: data_oe=0 immediately, all outputs at reset values.
  - Stimulus: sp=1 with a matching cas and INTA pulses.
  - Response: no output ever asserts.
